// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST signature checker.
// Optional mask compare is enabled with BIST_SIG_MASK_EN.
package bist_pkg;

  localparam int SIG_W_DEF = 15;

  localparam logic [SIG_W_DEF-1:0] GOLDEN_SIG_DEF = 15'h0000;

  typedef enum logic [2:0] {
    BS_IDLE    = 3'd0,
    BS_SEED    = 3'd1,
    BS_FLUSH   = 3'd2,
    BS_RUN     = 3'd3,
    BS_SETTLE  = 3'd4,
    BS_COMPARE = 3'd5,
    BS_DONE    = 3'd6
  } bist_state_t;

endpackage

// File: rtl/bist_sig_checker_if.sv
// Control and signature bus between test control / MISR and the BIST checker.
// The SIG_MASK signal exists only when BIST_SIG_MASK_EN is defined.
interface bist_sig_checker_if
  import bist_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF
) ();

  logic             start;
  logic [SIG_W-1:0] hf;
`ifdef BIST_SIG_MASK_EN
  logic [SIG_W-1:0] sig_mask;
`endif
  logic             tpg_load;
  logic             tpg_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [SIG_W-1:0] sig_out;

  modport master (
`ifdef BIST_SIG_MASK_EN
    output sig_mask,
`endif
    output start,
    output hf,
    input  tpg_load,
    input  tpg_en,
    input  busy,
    input  done,
    input  pass,
    input  fail,
    input  sig_out
  );

  modport slave (
`ifdef BIST_SIG_MASK_EN
    input  sig_mask,
`endif
    input  start,
    input  hf,
    output tpg_load,
    output tpg_en,
    output busy,
    output done,
    output pass,
    output fail,
    output sig_out
  );

endinterface

// File: rtl/bist_down_counter.sv
// Loadable down-counter that times the FLUSH, RUN and SETTLE phases.
// Load has priority over decrement; the zero flag reflects the registered count.
module bist_down_counter
  import bist_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/bist_sig_checker.sv
// BIST sequencer: seeds and runs the pattern generator, then compares the MISR signature.
// Defining BIST_SIG_MASK_EN adds a per-bit don't-care mask to the compare.
module bist_sig_checker
  import bist_pkg::*;
#(
  parameter int               SIG_W         = SIG_W_DEF,
  parameter int               CNT_W         = 16,
  parameter int               N_PATTERNS    = 1000,
  parameter int               FLUSH_CYCLES  = 16,
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [SIG_W-1:0] GOLDEN_SIG    = SIG_W'(GOLDEN_SIG_DEF)
) (
  input logic               clk,
  input logic               rst_n,
  bist_sig_checker_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'(BS_IDLE);
  localparam logic [2:0] ST_SEED    = 3'(BS_SEED);
  localparam logic [2:0] ST_FLUSH   = 3'(BS_FLUSH);
  localparam logic [2:0] ST_RUN     = 3'(BS_RUN);
  localparam logic [2:0] ST_SETTLE  = 3'(BS_SETTLE);
  localparam logic [2:0] ST_COMPARE = 3'(BS_COMPARE);
  localparam logic [2:0] ST_DONE    = 3'(BS_DONE);

  localparam logic [CNT_W-1:0] FLUSH_LD  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LD    = CNT_W'(N_PATTERNS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic             w_load;
  logic             w_dec;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;
  logic [SIG_W-1:0] w_mask;
  logic             w_match;

  logic             r_tpg_load;
  logic             r_tpg_en;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic [SIG_W-1:0] r_sig_out;

`ifdef BIST_SIG_MASK_EN
  assign w_mask = bus.sig_mask;
`else
  assign w_mask = '0;
`endif

  // Masked bits are don't-care; with no mask this is plain equality.
  assign w_match = (((bus.hf ^ GOLDEN_SIG) & ~w_mask) == '0);

  bist_down_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = ST_SEED;
      end
      ST_SEED: begin
        w_load     = 1'b1;
        w_load_val = FLUSH_LD;
        w_next     = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = RUN_LD;
          w_next     = ST_RUN;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_zero) begin
          w_load     = 1'b1;
          w_load_val = SETTLE_LD;
          w_next     = ST_SETTLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_zero) w_next = ST_COMPARE;
        else        w_dec  = 1'b1;
      end
      ST_COMPARE: begin
        w_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.start) w_next = ST_SEED;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decode the next state so each one is a flop aligned with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tpg_load <= 1'b0;
      r_tpg_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_sig_out  <= '0;
    end else begin
      r_state    <= w_next;
      r_tpg_load <= (w_next == ST_SEED);
      r_tpg_en   <= (w_next == ST_RUN);
      r_busy     <= (w_next != ST_IDLE) && (w_next != ST_DONE);
      r_done     <= (w_next == ST_DONE);
      if (r_state == ST_COMPARE) begin
        r_sig_out <= bus.hf;
        r_pass    <= w_match;
        r_fail    <= ~w_match;
      end else if (w_next != ST_DONE) begin
        r_pass <= 1'b0;
        r_fail <= 1'b0;
      end
    end
  end

  assign bus.tpg_load = r_tpg_load;
  assign bus.tpg_en   = r_tpg_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.pass     = r_pass;
  assign bus.fail     = r_fail;
  assign bus.sig_out  = r_sig_out;

endmodule
